// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Widths here are fixed by the CPU31 memory bus.
package dmem_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 4;
    localparam int CD_W   = 8;

    localparam logic [ADDR_W-1:0] ADDR_STEP = 32'd4;

    typedef enum logic {
        S_CPU = 1'b0,
        S_DBG = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_port_mux.sv
// Combinational steering of the DMEM port between the core and the debug requester.
module dmem_port_mux
    import dmem_arb_pkg::*;
(
    input  arb_state_t        state,
    input  logic              cpu_dmem_ena,
    input  logic              cpu_dmem_w,
    input  logic [ADDR_W-1:0] cpu_dmem_addr,
    input  logic [DATA_W-1:0] cpu_dmem_wdata,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              mem_ena,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    // While the debug side owns the port every core request is dropped.
    always_comb begin
        mem_ena   = cpu_dmem_ena;
        mem_w     = cpu_dmem_w;
        mem_addr  = cpu_dmem_addr;
        mem_wdata = cpu_dmem_wdata;
        if (state == S_DBG) begin
            mem_ena   = 1'b1;
            mem_w     = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the DMEM port between the CPU31 core and a debug/host requester.
// Define DMEM_ARB_BURST_EN to honour dbg_len for multi-word read bursts.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int CPU_MIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_run,
    output logic              cpu_ena,
    input  logic              cpu_dmem_ena,
    input  logic              cpu_dmem_w,
    input  logic              cpu_dmem_r,
    input  logic [ADDR_W-1:0] cpu_dmem_addr,
    input  logic [DATA_W-1:0] cpu_dmem_wdata,
    output logic [DATA_W-1:0] cpu_dmem_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [LEN_W-1:0]  dbg_len,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_busy,
    output logic              mem_ena,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(CPU_MIN_CYCLES);

    arb_state_t        state_q;
    logic [CD_W-1:0]   cooldown_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic              dbg_ack_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              last_word;

    // The core's read strobe carries no information for a combinational DMEM.
    logic unused_cpu_r;
    assign unused_cpu_r = cpu_dmem_r;

`ifdef DMEM_ARB_BURST_EN
    logic [LEN_W-1:0] cnt_q;
    assign last_word = (cnt_q == '0);
`else
    logic unused_len;
    assign unused_len = ^dbg_len;
    assign last_word  = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_CPU;
            cooldown_q  <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
`ifdef DMEM_ARB_BURST_EN
            cnt_q       <= '0;
`endif
        end else begin
            dbg_ack_q <= 1'b0;
            case (state_q)
                S_CPU: begin
                    if (cooldown_q != '0) begin
                        cooldown_q <= cooldown_q - CD_W'(1);
                    end else if (dbg_req) begin
                        state_q <= S_DBG;
                        addr_q  <= dbg_addr;
                        we_q    <= dbg_we;
`ifdef DMEM_ARB_BURST_EN
                        cnt_q   <= dbg_we ? '0 : dbg_len;
`endif
                    end
                end
                S_DBG: begin
                    dbg_ack_q <= 1'b1;
                    if (!we_q) begin
                        dbg_rdata_q <= mem_rdata;
                    end
                    addr_q <= addr_q + ADDR_STEP;
                    if (last_word) begin
                        state_q    <= S_CPU;
                        cooldown_q <= CD_LOAD;
                    end
`ifdef DMEM_ARB_BURST_EN
                    else begin
                        cnt_q <= cnt_q - LEN_W'(1);
                    end
`endif
                end
                default: state_q <= S_CPU;
            endcase
        end
    end

    assign cpu_ena        = cpu_run & (state_q == S_CPU);
    assign dbg_busy       = (state_q == S_DBG);
    assign dbg_ack        = dbg_ack_q;
    assign dbg_rdata      = dbg_rdata_q;
    assign cpu_dmem_rdata = mem_rdata;

    dmem_port_mux u_port_mux (
        .state          (state_q),
        .cpu_dmem_ena   (cpu_dmem_ena),
        .cpu_dmem_w     (cpu_dmem_w),
        .cpu_dmem_addr  (cpu_dmem_addr),
        .cpu_dmem_wdata (cpu_dmem_wdata),
        .dbg_we         (we_q),
        .dbg_addr       (addr_q),
        .dbg_wdata      (dbg_wdata),
        .mem_ena        (mem_ena),
        .mem_w          (mem_w),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64-word behavioural DMEM (preloaded mem[i]=i).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_run;
    logic        cpu_ena;
    logic        cpu_dmem_ena, cpu_dmem_w, cpu_dmem_r;
    logic [31:0] cpu_dmem_addr, cpu_dmem_wdata, cpu_dmem_rdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic [3:0]  dbg_len;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_busy;
    logic        mem_ena, mem_w;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int passes = 0;

    logic [31:0] mem [0:63];
    logic        loaded = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
            loaded <= 1'b1;
        end else if (mem_ena && mem_w) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    dmem_arbiter #(.CPU_MIN_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_run        (cpu_run),
        .cpu_ena        (cpu_ena),
        .cpu_dmem_ena   (cpu_dmem_ena),
        .cpu_dmem_w     (cpu_dmem_w),
        .cpu_dmem_r     (cpu_dmem_r),
        .cpu_dmem_addr  (cpu_dmem_addr),
        .cpu_dmem_wdata (cpu_dmem_wdata),
        .cpu_dmem_rdata (cpu_dmem_rdata),
        .dbg_req        (dbg_req),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_len        (dbg_len),
        .dbg_ack        (dbg_ack),
        .dbg_rdata      (dbg_rdata),
        .dbg_busy       (dbg_busy),
        .mem_ena        (mem_ena),
        .mem_w          (mem_w),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One cycle runs from negedge to negedge; inputs change just after the negedge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_cooldown();
        for (int i = 0; i < 4; i++) cyc();
    endtask

    task automatic dbg_read(input logic [31:0] a, input logic [3:0] l);
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = a;
        dbg_len  = l;
    endtask

    int gap;

    initial begin
        rst = 1'b0; cpu_run = 1'b0;
        cpu_dmem_ena = 1'b0; cpu_dmem_w = 1'b0; cpu_dmem_r = 1'b0;
        cpu_dmem_addr = '0; cpu_dmem_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_len = '0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_cpu_ena_off", 32'(cpu_ena), 32'd0);
        chk("rst_busy", 32'(dbg_busy), 32'd0);
        chk("rst_ack", 32'(dbg_ack), 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        cpu_run = 1'b1; #1;
        chk("rst_cpu_ena_run", 32'(cpu_ena), 32'd1);

        // Core store passes straight through
        cyc(); rst = 1'b1;
        cyc();
        cpu_dmem_ena = 1'b1; cpu_dmem_w = 1'b1;
        cpu_dmem_addr = 32'h10; cpu_dmem_wdata = 32'hDEADBEEF; #1;
        chk("core_ena", 32'(cpu_ena), 32'd1);
        chk("core_mem_w", 32'(mem_w), 32'd1);
        chk("core_mem_addr", mem_addr, 32'h10);
        chk("core_mem_wdata", mem_wdata, 32'hDEADBEEF);
        cyc(); cpu_dmem_ena = 1'b0; cpu_dmem_w = 1'b0; #1;
        chk("core_store_mem", mem[4], 32'hDEADBEEF);
        chk("core_no_ack", 32'(dbg_ack), 32'd0);

        // Single debug write
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678; #1;
        chk("dw_req_cycle_busy", 32'(dbg_busy), 32'd0);
        cyc(); #1;
        chk("dw_busy", 32'(dbg_busy), 32'd1);
        chk("dw_halt", 32'(cpu_ena), 32'd0);
        chk("dw_mem_w", 32'(mem_w), 32'd1);
        chk("dw_mem_addr", mem_addr, 32'h20);
        chk("dw_mem_wdata", mem_wdata, 32'h12345678);
        chk("dw_no_early_ack", 32'(dbg_ack), 32'd0);
        cyc(); dbg_req = 1'b0; #1;
        chk("dw_ack", 32'(dbg_ack), 32'd1);
        chk("dw_released", 32'(cpu_ena), 32'd1);
        chk("dw_mem", mem[8], 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("dw_core_owns", {30'd0, dbg_busy, cpu_ena}, 32'd1);
        end

        // Back-to-back single reads under a held request; core store during S_DBG dropped
        dbg_read(32'h8, 4'd0); dbg_wdata = '0;
        cyc();
        cpu_dmem_ena = 1'b1; cpu_dmem_w = 1'b1;
        cpu_dmem_addr = 32'h30; cpu_dmem_wdata = 32'hAAAA5555; #1;
        chk("rd1_busy", 32'(dbg_busy), 32'd1);
        chk("rd1_mem_w", 32'(mem_w), 32'd0);
        chk("rd1_mem_addr", mem_addr, 32'h8);
        cyc(); cpu_dmem_ena = 1'b0; cpu_dmem_w = 1'b0; #1;
        chk("rd1_ack", 32'(dbg_ack), 32'd1);
        chk("rd1_rdata", dbg_rdata, 32'd2);
        chk("rd1_core_store_dropped", mem[12], 32'd12);
        dbg_addr = 32'hC;
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(); #1;
            if (dbg_busy) break;
            if (cpu_ena && !dbg_ack) gap++;
        end
        chk("held_req_gap", 32'(gap), 32'd4);
        chk("rd2_busy", 32'(dbg_busy), 32'd1);
        chk("rd2_mem_addr", mem_addr, 32'hC);
        cyc(); dbg_req = 1'b0; #1;
        chk("rd2_ack", 32'(dbg_ack), 32'd1);
        chk("rd2_rdata", dbg_rdata, 32'd3);
        wait_cooldown();

`ifdef DMEM_ARB_BURST_EN
        // Four-word burst read from address 0
        dbg_read(32'h0, 4'd3);
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk("burst_busy", 32'(dbg_busy), 32'd1);
            chk("burst_mem_addr", mem_addr, 32'(4 * k));
            if (k > 0) begin
                chk("burst_ack", 32'(dbg_ack), 32'd1);
                chk("burst_rdata", dbg_rdata, 32'(k - 1));
            end
        end
        cyc(); dbg_req = 1'b0; #1;
        chk("burst_last_ack", 32'(dbg_ack), 32'd1);
        chk("burst_last_rdata", dbg_rdata, 32'd3);
        chk("burst_released", 32'(cpu_ena), 32'd1);
        wait_cooldown();

        // Address wrap at the top of the space
        dbg_read(32'hFFFFFFFC, 4'd1);
        cyc(); #1;
        chk("wrap_addr0", mem_addr, 32'hFFFFFFFC);
        cyc(); #1;
        chk("wrap_addr1", mem_addr, 32'h0);
        chk("wrap_rdata0", dbg_rdata, 32'd63);
        cyc(); dbg_req = 1'b0; #1;
        chk("wrap_rdata1", dbg_rdata, 32'd0);
        chk("wrap_busy", 32'(dbg_busy), 32'd0);
        wait_cooldown();
`else
        // Length field ignored: one word per grant
        dbg_read(32'h4, 4'd3);
        cyc(); #1;
        chk("single_busy", 32'(dbg_busy), 32'd1);
        cyc(); dbg_req = 1'b0; #1;
        chk("single_ack", 32'(dbg_ack), 32'd1);
        chk("single_rdata", dbg_rdata, 32'd1);
        chk("single_done", 32'(dbg_busy), 32'd0);
        cyc(); #1;
        chk("single_one_ack", 32'(dbg_ack), 32'd0);
        wait_cooldown();

        dbg_read(32'hFFFFFFFC, 4'd1);
        cyc(); #1;
        chk("wrap_addr0", mem_addr, 32'hFFFFFFFC);
        cyc(); dbg_req = 1'b0; #1;
        chk("wrap_rdata0", dbg_rdata, 32'd63);
        chk("wrap_busy", 32'(dbg_busy), 32'd0);
        wait_cooldown();
`endif

        // Asynchronous reset in the middle of a debug grant
        dbg_read(32'h0, 4'd3);
        cyc();
`ifdef DMEM_ARB_BURST_EN
        cyc();
`endif
        #1;
        chk("mid_rst_busy_before", 32'(dbg_busy), 32'd1);
        rst = 1'b0; #1;
        chk("mid_rst_busy", 32'(dbg_busy), 32'd0);
        chk("mid_rst_cpu_ena", 32'(cpu_ena), 32'd1);
        chk("mid_rst_ack", 32'(dbg_ack), 32'd0);
        cpu_run = 1'b0; #1;
        chk("mid_rst_cpu_ena_run0", 32'(cpu_ena), 32'd0);
        cyc(); #1;
        chk("mid_rst_no_ack", 32'(dbg_ack), 32'd0);
        rst = 1'b1;
        dbg_read(32'h4, 4'd0);
        cyc(); #1;
        chk("post_rst_grant", 32'(dbg_busy), 32'd1);
        chk("post_rst_addr", mem_addr, 32'h4);
        cyc(); dbg_req = 1'b0; #1;
        chk("post_rst_rdata", dbg_rdata, 32'd1);
        chk("post_rst_ack", 32'(dbg_ack), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
